// File: rtl/buzzer_melody_sequencer.sv
// Walks a constant note table and drives the buzzer driver's freq/enable with ms-accurate note and gap lengths.
// Optional MELODY_LOOP_EN adds a loop input that restarts the melody instead of finishing.
module buzzer_melody_sequencer #(
    parameter int unsigned CLK_HZ    = 100_000_000,
    parameter int unsigned NUM_NOTES = 16,
    parameter int unsigned GAP_MS    = 20
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         stop,
`ifdef MELODY_LOOP_EN
    input  logic                         loop,
`endif
    output logic [19:0]                  freq,
    output logic                         enable,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(NUM_NOTES)-1:0] note_idx
);

    localparam int unsigned TICK     = CLK_HZ / 1000;
    localparam int unsigned PRE_W    = (TICK > 1) ? $clog2(TICK) : 1;
    localparam int unsigned IDX_W    = $clog2(NUM_NOTES);
    localparam int unsigned FREQ_W   = 20;
    localparam int unsigned DUR_W    = 16;
    localparam int unsigned ENTRY_W  = FREQ_W + DUR_W;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_NOTES - 1);
    localparam logic [DUR_W-1:0] GAP_LAST = DUR_W'(GAP_MS - 1);

    typedef enum logic [2:0] {IDLE, LOAD, PLAY, GAP, DONE} state_t;

    // Note table: {freq_hz, dur_ms}; dur_ms == 0 marks the end of the melody.
    function automatic logic [ENTRY_W-1:0] note_rom(input logic [IDX_W-1:0] i);
        logic [ENTRY_W-1:0] e;
        case (i)
            IDX_W'(0): e = {20'd262, 16'd200};
            IDX_W'(1): e = {20'd294, 16'd200};
            IDX_W'(2): e = {20'd330, 16'd200};
            IDX_W'(3): e = {20'd0,   16'd100};
            IDX_W'(4): e = {20'd392, 16'd400};
            default:   e = '0;
        endcase
        return e;
    endfunction

    state_t              state;
    logic [PRE_W-1:0]    pre_cnt;
    logic [DUR_W-1:0]    ms_cnt;
    logic [DUR_W-1:0]    dur_q;

    logic [ENTRY_W-1:0]  rom_c;
    logic [FREQ_W-1:0]   rom_freq_c;
    logic [DUR_W-1:0]    rom_dur_c;
    logic                ms_tick_c;
    logic                ms_last_c;
    logic                loop_c;

    assign rom_c      = note_rom(note_idx);
    assign rom_freq_c = rom_c[ENTRY_W-1:DUR_W];
    assign rom_dur_c  = rom_c[DUR_W-1:0];
    assign ms_tick_c  = (pre_cnt == PRE_LAST);
    assign ms_last_c  = (state == PLAY) ? (ms_cnt == dur_q - DUR_W'(1)) : (ms_cnt == GAP_LAST);

`ifdef MELODY_LOOP_EN
    assign loop_c = loop;
`else
    assign loop_c = 1'b0;
`endif

    // Sequencer state machine; all outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pre_cnt  <= '0;
            ms_cnt   <= '0;
            dur_q    <= '0;
            freq     <= '0;
            enable   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            note_idx <= '0;
        end else if (stop && (state != IDLE)) begin
            state    <= IDLE;
            pre_cnt  <= '0;
            ms_cnt   <= '0;
            freq     <= '0;
            enable   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            note_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start && !stop) begin
                        state    <= LOAD;
                        busy     <= 1'b1;
                        note_idx <= '0;
                    end
                end
                LOAD: begin
                    if (rom_dur_c == '0) begin
                        if (loop_c) begin
                            note_idx <= '0;
                        end else begin
                            state  <= DONE;
                            done   <= 1'b1;
                            enable <= 1'b0;
                            freq   <= '0;
                        end
                    end else begin
                        state   <= PLAY;
                        dur_q   <= rom_dur_c;
                        freq    <= rom_freq_c;
                        enable  <= (rom_freq_c != '0);
                        pre_cnt <= '0;
                        ms_cnt  <= '0;
                    end
                end
                PLAY, GAP: begin
                    if (!ms_tick_c) begin
                        pre_cnt <= pre_cnt + PRE_W'(1);
                    end else begin
                        pre_cnt <= '0;
                        if (!ms_last_c) begin
                            ms_cnt <= ms_cnt + DUR_W'(1);
                        end else if ((state == PLAY) && (GAP_MS > 0)) begin
                            state  <= GAP;
                            enable <= 1'b0;
                            ms_cnt <= '0;
                        end else begin
                            // Advance step: next entry, wrap when looping, or finish.
                            enable <= 1'b0;
                            ms_cnt <= '0;
                            if (note_idx != IDX_LAST) begin
                                note_idx <= note_idx + IDX_W'(1);
                                state    <= LOAD;
                            end else if (loop_c) begin
                                note_idx <= '0;
                                state    <= LOAD;
                            end else begin
                                state <= DONE;
                                done  <= 1'b1;
                                freq  <= '0;
                            end
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
